routa_sevenseg_driver: RTL

- Consumes the processor's 16-bit `routa` result bus and shows it in hex on a 4-digit multiplexed common-anode seven-segment display.
- Sits directly downstream of KGP_RISC at board top level.
- A stability filter suppresses transient mid-instruction values; a refresh counter time-multiplexes the digits.

---
 rtl/routa_sevenseg_driver.sv | 71 +++++++
 1 files changed

// File: rtl/routa_sevenseg_driver.sv
// routa_sevenseg_driver: stability-filtered hex display of routa on a 4-digit multiplexed common-anode seven-segment display.
// Optional LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module routa_sevenseg_driver #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int STABLE_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] routa,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [15:0] disp_val,
  output logic        update_pulse
);
  localparam int SW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  localparam int RW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_CYCLES - 1);
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0]   cand_q, disp_q, disp_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d, nib;
  logic [6:0]    seg_q, seg_d;
  logic          pulse_q, load, blank;
  // cand always tracks routa one edge late; only the counter decides acceptance
  always_comb begin
    stab_d = (routa != cand_q) ? '0 : (stab_q < STAB_MAX) ? stab_q + 1'b1 : stab_q;
    load   = (routa == cand_q) && (stab_q == STAB_MAX) && (disp_q != cand_q);
    disp_d = load ? cand_q : disp_q;
    ref_d  = (ref_q == REF_MAX) ? '0 : ref_q + 1'b1;
    idx_d  = (ref_q == REF_MAX) ? idx_q + 2'd1 : idx_q;
    nib    = disp_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    blank  = (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'h0000);
`else
    blank  = 1'b0;
`endif
    an_d   = ~(4'b0001 << idx_q);
    seg_d  = blank ? 7'h7F : HEX[nib];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q  <= '0;
      stab_q  <= '0;
      disp_q  <= '0;
      pulse_q <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
    end else begin
      cand_q  <= routa;
      stab_q  <= stab_d;
      disp_q  <= disp_d;
      pulse_q <= load;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end
  assign an           = an_q;
  assign seg          = seg_q;
  assign dp           = 1'b1;
  assign disp_val     = disp_q;
  assign update_pulse = pulse_q;
endmodule
